// File: rtl/rt_ibex_window_spill_fill.sv
// rtl/rt_ibex_window_spill_fill.sv - register-window frame spill/fill engine between window regfile and OBI data port
//
// Moves one frame (WindowSize regs + mcause + mepc) between the windowed
// register file and a memory stack at SpillBaseAddr, one word per bus
// transaction, and tracks how many frames are currently spilled.
//
// Ports:
//   clk_i, rst_i                      clock, async active-high reset
//   spill_req_i, fill_req_i, win_sel_i  transfer start (IDLE only), target window
//   busy_o, done_o, err_o, depth_o    status, completion/error pulses, stack depth
//   rf_win_o, rf_off_o, rf_rdata_i    regfile read port (combinational data)
//   rf_we_o, rf_wdata_o               regfile write port
//   data_req_o .. data_err_i          OBI-style data port, one outstanding access
module rt_ibex_window_spill_fill #(
    parameter int unsigned  DataWidth           = 32,
    parameter int unsigned  WindowSize          = 7,
    parameter int unsigned  NUM_RegisterWindows = 4,
    parameter int unsigned  MaxDepth            = 8,
    parameter logic [31:0]  SpillBaseAddr       = 32'h0000_F000,
    localparam int unsigned WinW                = $clog2(NUM_RegisterWindows),
    localparam int unsigned DepthW              = $clog2(MaxDepth + 1)
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 spill_req_i,
    input  logic                 fill_req_i,
    input  logic [WinW-1:0]      win_sel_i,
    output logic                 busy_o,
    output logic                 done_o,
    output logic                 err_o,
    output logic [DepthW-1:0]    depth_o,
    output logic [WinW-1:0]      rf_win_o,
    output logic [3:0]           rf_off_o,
    input  logic [DataWidth-1:0] rf_rdata_i,
    output logic                 rf_we_o,
    output logic [DataWidth-1:0] rf_wdata_o,
    output logic                 data_req_o,
    input  logic                 data_gnt_i,
    output logic                 data_we_o,
    output logic [3:0]           data_be_o,
    output logic [31:0]          data_addr_o,
    output logic [DataWidth-1:0] data_wdata_o,
    input  logic                 data_rvalid_i,
    input  logic [DataWidth-1:0] data_rdata_i,
    input  logic                 data_err_i
);

    localparam int unsigned FrameWords = WindowSize + 2;
    localparam logic [3:0]  LastWord   = 4'(FrameWords - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RSP  = 2'd2
    } state_e;

    state_e              state_q, state_d;
    logic                spill_q, spill_d;
    logic [WinW-1:0]     win_q, win_d;
    logic [3:0]          cnt_q, cnt_d;
    logic [DepthW-1:0]   depth_q, depth_d;
    logic                err_q, err_d;

    logic                busy;
    logic                last_word;
    logic                rsp_ok;
    logic                rsp_bad;
    logic [DepthW-1:0]   frame;
    logic [31:0]         word_idx;

    assign busy      = (state_q != IDLE);
    assign last_word = (cnt_q == LastWord);
    // Responses only count while waiting for one; stale ones in IDLE/REQ are dropped.
    assign rsp_ok    = (state_q == RSP) && data_rvalid_i && !data_err_i;
    assign rsp_bad   = (state_q == RSP) && data_rvalid_i && data_err_i;

    // Spill pushes onto the next free frame, fill pops the top one.
    assign frame    = spill_q ? depth_q : (depth_q - DepthW'(1));
    assign word_idx = 32'(frame) * 32'(FrameWords) + 32'(cnt_q);

    always_comb begin
        state_d = state_q;
        spill_d = spill_q;
        win_d   = win_q;
        cnt_d   = cnt_q;
        depth_d = depth_q;
        err_d   = 1'b0;
        case (state_q)
            IDLE: begin
                // Spill has priority when both requests arrive together.
                if (spill_req_i) begin
                    if (depth_q == DepthW'(MaxDepth)) begin
                        err_d = 1'b1;
                    end else begin
                        state_d = REQ;
                        spill_d = 1'b1;
                        win_d   = win_sel_i;
                        cnt_d   = 4'd0;
                    end
                end else if (fill_req_i) begin
                    if (depth_q == '0) begin
                        err_d = 1'b1;
                    end else begin
                        state_d = REQ;
                        spill_d = 1'b0;
                        win_d   = win_sel_i;
                        cnt_d   = 4'd0;
                    end
                end
            end
            REQ: begin
                if (data_gnt_i) begin
                    state_d = RSP;
                end
            end
            RSP: begin
                if (data_rvalid_i) begin
                    if (data_err_i) begin
                        state_d = IDLE;
                        cnt_d   = 4'd0;
                    end else if (last_word) begin
                        state_d = IDLE;
                        cnt_d   = 4'd0;
                        depth_d = spill_q ? (depth_q + DepthW'(1)) : (depth_q - DepthW'(1));
                    end else begin
                        state_d = REQ;
                        cnt_d   = cnt_q + 4'd1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            spill_q <= 1'b0;
            win_q   <= '0;
            cnt_q   <= 4'd0;
            depth_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            spill_q <= spill_d;
            win_q   <= win_d;
            cnt_q   <= cnt_d;
            depth_q <= depth_d;
            err_q   <= err_d;
        end
    end

    assign busy_o       = busy;
    assign depth_o      = depth_q;
    assign done_o       = rsp_ok && last_word;
    // Depth errors are flagged one cycle after the request; bus errors in the response cycle.
    assign err_o        = err_q | rsp_bad;
    assign rf_win_o     = busy ? win_q : '0;
    assign rf_off_o     = busy ? cnt_q : 4'd0;
    assign rf_we_o      = rsp_ok && !spill_q;
    assign rf_wdata_o   = rf_we_o ? data_rdata_i : '0;
    assign data_req_o   = (state_q == REQ);
    assign data_we_o    = (state_q == REQ) && spill_q;
    assign data_be_o    = 4'hF;
    assign data_addr_o  = busy ? (SpillBaseAddr + (word_idx << 2)) : 32'h0;
    assign data_wdata_o = (busy && spill_q) ? rf_rdata_i : '0;

endmodule
